// File: rtl/gol_pkg.sv
// ---------------------------------------------------------------------------
// gol_pkg
// Shared constants and helpers for the Game-of-Life grid engine.
//   BIRTH_CNT / SURV_MIN / SURV_MAX : B3/S23 rule thresholds
//   cell_idx(r, c, cols)            : flat bit index of cell (row r, col c)
//   wrap_idx(i, n)                  : i reduced modulo n into 0..n-1, also for
//                                     negative i (used for toroidal edges)
// ---------------------------------------------------------------------------
package gol_pkg;

  localparam logic [3:0] BIRTH_CNT = 4'd3;
  localparam logic [3:0] SURV_MIN  = 4'd2;
  localparam logic [3:0] SURV_MAX  = 4'd3;

  function automatic int cell_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  // SystemVerilog % keeps the sign of the dividend, so add n back before the
  // final reduction to map -1 onto n-1.
  function automatic int wrap_idx(input int i, input int n);
    return ((i % n) + n) % n;
  endfunction

endpackage

// File: rtl/gol_cell_next.sv
// ---------------------------------------------------------------------------
// gol_cell_next
// Next-generation value of a single cell under the B3/S23 rule.
// Ports:
//   neighbours [7:0] in  : live state of the eight surrounding cells
//   cur              in  : current state of this cell
//   next             out : state of this cell in the next generation
// ---------------------------------------------------------------------------
module gol_cell_next
  import gol_pkg::*;
(
  input  logic [7:0] neighbours,
  input  logic       cur,
  output logic       next
);

  logic [3:0] live_cnt;

  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      live_cnt = live_cnt + {3'b000, neighbours[i]};
    end
  end

  assign next = (live_cnt == BIRTH_CNT) |
                (cur & (live_cnt >= SURV_MIN) & (live_cnt <= SURV_MAX));

endmodule

// File: rtl/gol_grid_engine.sv
// ---------------------------------------------------------------------------
// gol_grid_engine
// Parametrised Conway Game-of-Life engine. Holds a ROWS x COLS grid, loads a
// seed and advances one generation per enabled clock, with toroidal or
// dead-boundary edges, a saturating generation counter and still-life /
// period-2 / extinction detection.
// Ports:
//   clk        in  : rising-edge clock
//   reset_n    in  : asynchronous active-low reset
//   load       in  : copy seed_in into the grid (beats enable and halted)
//   seed_in    in  : seed, bit r*COLS+c = cell (row r, col c)
//   enable     in  : advance one generation
//   grid_out   out : registered current grid, same bit map as seed_in
//   gen_count  out : generations since the last load, saturating
//   stable     out : last step left the grid unchanged
//   osc2       out : last step returned the grid from two generations back
//   extinct    out : grid is empty after the last step
//   halted     out : stepping frozen because the pattern settled
// ---------------------------------------------------------------------------
module gol_grid_engine
  import gol_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int WRAP           = 1,
  parameter int GEN_W          = 16,
  parameter int HALT_ON_STABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed_in,
  input  logic                 enable,
  output logic [ROWS*COLS-1:0] grid_out,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 osc2,
  output logic                 extinct,
  output logic                 halted
);

  localparam int N = ROWS * COLS;

  logic [N-1:0] grid;
  logic [N-1:0] prev_grid;
  logic [N-1:0] next_grid;

  // Neighbour gathering is resolved entirely at elaboration time: each cell
  // gets its eight neighbours wired either through modulo indexing (torus)
  // or tied to 0 when the neighbour falls outside the grid.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_used
          localparam int NR   = r + (k / 3) - 1;
          localparam int NC   = c + (k % 3) - 1;
          localparam int SLOT = (k < 4) ? k : k - 1;
          if (WRAP != 0) begin : g_wrap
            assign nb[SLOT] = grid[cell_idx(wrap_idx(NR, ROWS), wrap_idx(NC, COLS), COLS)];
          end else if (NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_inside
            assign nb[SLOT] = grid[cell_idx(NR, NC, COLS)];
          end else begin : g_outside
            assign nb[SLOT] = 1'b0;
          end
        end
      end
      gol_cell_next u_cell (
        .neighbours (nb),
        .cur        (grid[cell_idx(r, c, COLS)]),
        .next       (next_grid[cell_idx(r, c, COLS)])
      );
    end
  end

  logic is_still;
  logic is_dead;
  logic is_period2;

  // The period-2 test needs a genuine history: right after a load prev_grid
  // holds zeros rather than a real earlier generation, so a non-zero
  // generation count is required too.
  assign is_still   = (next_grid == grid);
  assign is_dead    = (next_grid == '0);
  assign is_period2 = (next_grid == prev_grid) && !is_still && (gen_count != '0);

  // Grid, history, counter and status flags all update together so the flags
  // always describe the step that produced the grid currently shown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grid      <= '0;
      prev_grid <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      osc2      <= 1'b0;
      extinct   <= 1'b0;
      halted    <= 1'b0;
    end else if (load) begin
      grid      <= seed_in;
      prev_grid <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      osc2      <= 1'b0;
      extinct   <= 1'b0;
      halted    <= 1'b0;
    end else if (enable && !halted) begin
      grid      <= next_grid;
      prev_grid <= grid;
      if (gen_count != '1) begin
        gen_count <= gen_count + 1'b1;
      end
      stable    <= is_still;
      osc2      <= is_period2;
      extinct   <= is_dead;
      halted    <= (HALT_ON_STABLE != 0) && (is_still || is_dead);
    end
  end

  assign grid_out = grid;

endmodule

// File: tb/tb_gol_grid_engine.sv
// ---------------------------------------------------------------------------
// tb_gol_grid_engine
// Self-checking bench for gol_grid_engine. Four instances share one stimulus
// stream: the default torus engine (tracked by a reference model and a
// scoreboard), a dead-boundary engine, a 4-bit-counter engine and an engine
// that never halts.
// ---------------------------------------------------------------------------
module tb_gol_grid_engine;

  localparam logic [63:0] BLINKER_H = 64'h0000_00e0_0000_0000;
  localparam logic [63:0] BLINKER_V = 64'h0000_4040_4000_0000;
  localparam logic [63:0] BLOCK     = 64'h0000_0000_0000_0303;
  localparam logic [63:0] EDGE_SEED = 64'h0000_0000_0000_0083;
  localparam logic [63:0] EDGE_WRAP = 64'h0100_0000_0000_0101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [63:0] seed_in;
  logic        enable;

  logic [63:0] m_grid_out;
  logic [15:0] m_gen;
  logic        m_stable, m_osc2, m_extinct, m_halted;
  logic [63:0] w_grid_out;
  logic [15:0] w_gen;
  logic        w_stable, w_osc2, w_extinct, w_halted;
  logic [63:0] s_grid_out;
  logic [3:0]  s_gen;
  logic        s_stable, s_osc2, s_extinct, s_halted;
  logic [63:0] h_grid_out;
  logic [15:0] h_gen;
  logic        h_stable, h_osc2, h_extinct, h_halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gol_grid_engine #(.WRAP(1), .GEN_W(16), .HALT_ON_STABLE(1)) dut_main (
    .clk(clk), .reset_n(reset_n), .load(load), .seed_in(seed_in), .enable(enable),
    .grid_out(m_grid_out), .gen_count(m_gen), .stable(m_stable), .osc2(m_osc2),
    .extinct(m_extinct), .halted(m_halted));

  gol_grid_engine #(.WRAP(0), .GEN_W(16), .HALT_ON_STABLE(1)) dut_nowrap (
    .clk(clk), .reset_n(reset_n), .load(load), .seed_in(seed_in), .enable(enable),
    .grid_out(w_grid_out), .gen_count(w_gen), .stable(w_stable), .osc2(w_osc2),
    .extinct(w_extinct), .halted(w_halted));

  gol_grid_engine #(.WRAP(1), .GEN_W(4), .HALT_ON_STABLE(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .load(load), .seed_in(seed_in), .enable(enable),
    .grid_out(s_grid_out), .gen_count(s_gen), .stable(s_stable), .osc2(s_osc2),
    .extinct(s_extinct), .halted(s_halted));

  gol_grid_engine #(.WRAP(1), .GEN_W(16), .HALT_ON_STABLE(0)) dut_nohalt (
    .clk(clk), .reset_n(reset_n), .load(load), .seed_in(seed_in), .enable(enable),
    .grid_out(h_grid_out), .gen_count(h_gen), .stable(h_stable), .osc2(h_osc2),
    .extinct(h_extinct), .halted(h_halted));

  typedef struct {
    int          step;
    logic [63:0] grid;
    logic [15:0] gen;
    logic        stable;
    logic        osc2;
    logic        extinct;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state for dut_main
  logic [63:0] md_grid, md_prev;
  logic [15:0] md_gen;
  logic        md_stable, md_osc2, md_extinct, md_halted;
  int          step_no = 0;

  // Straightforward cell-by-cell B3/S23 evaluation on an 8x8 grid
  function automatic logic [63:0] life_step(input logic [63:0] g, input bit wrap);
    logic [63:0] res = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              continue;
            end
            if (g[rr*8+cc]) cnt++;
          end
        end
        res[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return res;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    md_grid = '0; md_prev = '0; md_gen = '0;
    md_stable = 0; md_osc2 = 0; md_extinct = 0; md_halted = 0;
  endtask

  // Drive one cycle of inputs, advance the model and queue its prediction
  task automatic applyStimulus(input logic ld, input logic [63:0] seed, input logic en);
    exp_t e;
    logic [63:0] nxt;
    @(negedge clk);
    load = ld; seed_in = seed; enable = en;
    if (ld) begin
      md_grid = seed; md_prev = '0; md_gen = '0;
      md_stable = 0; md_osc2 = 0; md_extinct = 0; md_halted = 0;
    end else if (en && !md_halted) begin
      nxt        = life_step(md_grid, 1'b1);
      md_stable  = (nxt == md_grid);
      md_osc2    = (nxt == md_prev) && (nxt != md_grid) && (md_gen >= 1);
      md_extinct = (nxt == '0);
      md_halted  = md_stable || md_extinct;
      md_prev    = md_grid;
      md_grid    = nxt;
      md_gen     = md_gen + 16'd1;
    end
    step_no++;
    e.step = step_no; e.grid = md_grid; e.gen = md_gen;
    e.stable = md_stable; e.osc2 = md_osc2; e.extinct = md_extinct; e.halted = md_halted;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest prediction and compare it against dut_main
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cmp($sformatf("s%0d_grid", e.step),    m_grid_out,       e.grid);
      cmp($sformatf("s%0d_gen", e.step),     64'(m_gen),       64'(e.gen));
      cmp($sformatf("s%0d_stable", e.step),  64'(m_stable),    64'(e.stable));
      cmp($sformatf("s%0d_osc2", e.step),    64'(m_osc2),      64'(e.osc2));
      cmp($sformatf("s%0d_extinct", e.step), 64'(m_extinct),   64'(e.extinct));
      cmp($sformatf("s%0d_halted", e.step),  64'(m_halted),    64'(e.halted));
    end
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; seed_in = '0; enable = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    cmp("rst_main_grid", m_grid_out, 64'h0);
    cmp("rst_main_gen", 64'(m_gen), 64'h0);
    cmp("rst_main_flags", 64'({m_stable, m_osc2, m_extinct, m_halted}), 64'h0);
    cmp("rst_sat_gen", 64'(s_gen), 64'h0);
    reset_n = 1'b1;

    // Blinker: horizontal -> vertical -> horizontal with osc2
    applyStimulus(1'b1, BLINKER_H, 1'b0); checkOutput();
    applyStimulus(1'b0, BLINKER_H, 1'b1); checkOutput();
    cmp("blinker_vert", m_grid_out, BLINKER_V);
    applyStimulus(1'b0, BLINKER_H, 1'b1); checkOutput();
    cmp("blinker_back", m_grid_out, BLINKER_H);
    cmp("blinker_osc2", 64'(m_osc2), 64'h1);
    cmp("blinker_gen2", 64'(m_gen), 64'h2);

    // Block with load and enable together: load wins
    applyStimulus(1'b1, BLOCK, 1'b1); checkOutput();
    cmp("ldprio_grid", m_grid_out, BLOCK);
    cmp("ldprio_gen", 64'(m_gen), 64'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, BLOCK, 1'b1); checkOutput();
    end
    cmp("block_halt_gen", 64'(m_gen), 64'h1);
    cmp("block_halted", 64'(m_halted), 64'h1);
    cmp("nohalt_gen", 64'(h_gen), 64'h4);
    cmp("nohalt_stable", 64'(h_stable), 64'h1);
    cmp("nohalt_halted", 64'(h_halted), 64'h0);
    cmp("nohalt_grid", h_grid_out, BLOCK);

    // Edge behaviour: torus rotates the line, dead boundary kills it
    applyStimulus(1'b1, EDGE_SEED, 1'b0); checkOutput();
    applyStimulus(1'b0, EDGE_SEED, 1'b1); checkOutput();
    cmp("edge_wrap_grid", m_grid_out, EDGE_WRAP);
    cmp("edge_nowrap_grid", w_grid_out, 64'h0);
    cmp("edge_nowrap_extinct", 64'(w_extinct), 64'h1);
    cmp("edge_nowrap_halted", 64'(w_halted), 64'h1);
    applyStimulus(1'b0, EDGE_SEED, 1'b1); checkOutput();
    cmp("edge_wrap_back", m_grid_out, EDGE_SEED);

    // Asynchronous reset between clock edges
    applyStimulus(1'b1, BLINKER_H, 1'b0); checkOutput();
    applyStimulus(1'b0, BLINKER_H, 1'b1); checkOutput();
    @(negedge clk);
    enable = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    cmp("async_grid", m_grid_out, 64'h0);
    cmp("async_gen", 64'(m_gen), 64'h0);
    cmp("async_flags", 64'({m_stable, m_osc2, m_extinct, m_halted}), 64'h0);
    cmp("async_sat_grid", s_grid_out, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Saturating 4-bit counter on a running blinker
    applyStimulus(1'b1, BLINKER_H, 1'b0); checkOutput();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, BLINKER_H, 1'b1); checkOutput();
      if (i == 14) cmp("sat_gen14", 64'(s_gen), 64'hE);
      if (i == 19) begin
        cmp("sat_gen19", 64'(s_gen), 64'hF);
        cmp("sat_grid19", s_grid_out, BLINKER_V);
      end
      if (i == 20) begin
        cmp("sat_gen20", 64'(s_gen), 64'hF);
        cmp("sat_grid20", s_grid_out, BLINKER_H);
        cmp("sat_osc2", 64'(s_osc2), 64'h1);
      end
    end
    cmp("main_gen20", 64'(m_gen), 64'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
